// File: rtl/alsu_pkg.sv
// Shared ALSU types: opcode enum, packed command word, field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alsu_pkg;

  localparam int AB_W   = 3;
  localparam int OUT_W  = 6;
  localparam int LEDS_W = 16;
  localparam int CMD_W  = 16;
  localparam int RSP_W  = OUT_W + LEDS_W;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_ADD    = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_e;

  // Bit order matches cmd_data: {A, B, opcode, cin, serial_in, direction,
  // red_op_A, red_op_B, bypass_A, bypass_B}, MSB first.
  typedef struct packed {
    logic [AB_W-1:0] a;
    logic [AB_W-1:0] b;
    opcode_e         opcode;
    logic            cin;
    logic            serial_in;
    logic            direction;
    logic            red_op_a;
    logic            red_op_b;
    logic            bypass_a;
    logic            bypass_b;
  } cmd_t;

endpackage

// File: rtl/alsu_rsp_fifo.sv
// Response buffer: DEPTH-entry FIFO of captured {out, leds} words.
// Latency: a write is visible at rd_dat the cycle after the write edge.
// Backpressure: head held stable while rd_vld && !rd_rdy; pop from empty ignored.
// Ports: clk, reset (async, active-high); wr_vld/wr_dat write side;
//        rd_vld (not empty), rd_rdy (pop), rd_dat (head entry, 0 when empty).
module alsu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_vld = (count != '0);
  assign do_wr  = wr_vld && (count != CW'(DEPTH));
  assign do_rd  = rd_rdy && rd_vld;
  // Masking the head with rd_vld makes the outputs drop to 0 the moment
  // reset clears the count, without resetting the storage array.
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_next(wr_ptr);
      if (do_rd) rd_ptr <= ptr_next(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// Issues commands to a pipelined ALSU and buffers its results in order.
// Latency: pins driven the cycle after accept; response valid PIPE_LAT edges after accept.
// Backpressure: credit based; cmd_ready drops once in-flight + buffered reaches DEPTH.
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_data command
//        side; rsp_valid/rsp_ready/rsp_out/rsp_leds response side; A..bypass_B
//        registered ALSU inputs; out/leds ALSU results.
module alsu_cmd_issuer
  import alsu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_W-1:0]  rsp_out,
  output logic [LEDS_W-1:0] rsp_leds,
  output logic [AB_W-1:0]   A,
  output logic [AB_W-1:0]   B,
  output logic [2:0]        opcode,
  output logic              cin,
  output logic              serial_in,
  output logic              direction,
  output logic              red_op_A,
  output logic              red_op_B,
  output logic              bypass_A,
  output logic              bypass_B,
  input  logic [OUT_W-1:0]  out,
  input  logic [LEDS_W-1:0] leds
);

  localparam int CW = $clog2(DEPTH + 1);

  cmd_t                cmd;
  cmd_t                issue_q;
  logic [CW-1:0]       credits;
  logic [PIPE_LAT-1:0] slot_vld;
  logic [RSP_W-1:0]    rsp_dat;
  logic                accept;
  logic                pop;

  assign cmd       = cmd_t'(cmd_data);
  assign cmd_ready = (credits < CW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Pins carry an accepted command for one cycle, otherwise the all-zero
  // IDLE word (an AND of zeros, so the ALSU settles to out = 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       issue_q <= '0;
    else if (accept) issue_q <= cmd;
    else             issue_q <= '0;
  end

  assign A         = issue_q.a;
  assign B         = issue_q.b;
  assign opcode    = issue_q.opcode;
  assign cin       = issue_q.cin;
  assign serial_in = issue_q.serial_in;
  assign direction = issue_q.direction;
  assign red_op_A  = issue_q.red_op_a;
  assign red_op_B  = issue_q.red_op_b;
  assign bypass_A  = issue_q.bypass_a;
  assign bypass_B  = issue_q.bypass_b;

  // Bit k set means a command accepted k+1 edges ago is still in the ALSU;
  // the top bit marks the edge on which its result is on out/leds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) slot_vld <= '0;
    else       slot_vld <= {slot_vld[PIPE_LAT-2:0], accept};
  end

  // Credits cover both in-flight slots and buffered results, so the FIFO
  // can never be written while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                credits <= '0;
    else if (accept && !pop)  credits <= credits + CW'(1);
    else if (!accept && pop)  credits <= credits - CW'(1);
  end

  alsu_rsp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (slot_vld[PIPE_LAT-1]),
    .wr_dat ({out, leds}),
    .rd_vld (rsp_valid),
    .rd_rdy (rsp_ready),
    .rd_dat (rsp_dat)
  );

  assign rsp_out  = rsp_dat[RSP_W-1:LEDS_W];
  assign rsp_leds = rsp_dat[LEDS_W-1:0];

endmodule
